dmem_responder: RTL and testbench



---
 rtl/dmem_if.sv | 18 +
 rtl/dmem_responder.sv | 124 ++++++++++++
 tb/tb_dmem_responder.sv | 175 +++++++++++++++++
 3 files changed

// File: rtl/dmem_if.sv
// Request/response bundle between the MEM stage and dmem_responder.
interface dmem_if;
  localparam int unsigned DATA_W = 16;

  logic              MemOp;
  logic              MemWrite;
  logic [DATA_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic [DATA_W-1:0] rdata;
  logic              stall;
  logic              done;
  logic              err;

  modport master (output MemOp, MemWrite, addr, wdata,
                  input  rdata, stall, done, err);
  modport slave  (input  MemOp, MemWrite, addr, wdata,
                  output rdata, stall, done, err);
endinterface

// File: rtl/dmem_responder.sv
// Multi-cycle data-memory responder: stalls the pipeline LATENCY+1 cycles per LW/SW.
// Optional misaligned-access trap enabled by defining DMEM_ALIGN_CHECK_EN.
module dmem_responder #(
  parameter int unsigned LATENCY    = 4,
  parameter int unsigned ADDR_WIDTH = 10
) (
  input  logic   clk,
  input  logic   rst,
  dmem_if.slave  bus
);
  localparam int unsigned DATA_W = 16;
  localparam int unsigned CNT_W  = 4;
  localparam int unsigned DEPTH  = 1 << ADDR_WIDTH;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t                  state, state_nx;
  logic [CNT_W-1:0]        cnt, cnt_nx;
  logic [ADDR_WIDTH-1:0]   idx_q;
  logic [DATA_W-1:0]       wdata_q;
  logic                    we_q;
  logic [DATA_W-1:0]       rdata_q;
  logic                    done_q;
  logic                    accept_c, access_c, stall_c, misalign_c;
  logic [DATA_W-1:0]       mem [DEPTH];

`ifdef DMEM_ALIGN_CHECK_EN
  assign misalign_c = bus.addr[0];
`else
  assign misalign_c = 1'b0;
`endif

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
    end
  end

  // Next-state and control decode; MemOp is only looked at in IDLE
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    accept_c = 1'b0;
    access_c = 1'b0;
    stall_c  = 1'b0;
    case (state)
      IDLE: begin
        if (bus.MemOp) begin
          accept_c = 1'b1;
          stall_c  = 1'b1;
          if (misalign_c) begin
            state_nx = DONE;
          end else begin
            state_nx = BUSY;
            cnt_nx   = CNT_W'(LATENCY - 1);
          end
        end
      end
      BUSY: begin
        stall_c = 1'b1;
        if (cnt == '0) begin
          access_c = 1'b1;
          state_nx = DONE;
        end else begin
          cnt_nx = cnt - CNT_W'(1);
        end
      end
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Request latches and registered responses
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx_q   <= '0;
      wdata_q <= '0;
      we_q    <= 1'b0;
      rdata_q <= '0;
      done_q  <= 1'b0;
    end else begin
      if (accept_c) begin
        idx_q   <= bus.addr[ADDR_WIDTH:1];
        wdata_q <= bus.wdata;
        we_q    <= bus.MemWrite;
      end
      if (access_c && !we_q) begin
        rdata_q <= mem[idx_q];
      end else if (accept_c && misalign_c) begin
        rdata_q <= '0;
      end
      done_q <= (state_nx == DONE);
    end
  end

  // Backing array is deliberately not reset
  always_ff @(posedge clk) begin
    if (access_c && we_q) begin
      mem[idx_q] <= wdata_q;
    end
  end

`ifdef DMEM_ALIGN_CHECK_EN
  logic err_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) err_q <= 1'b0;
    else     err_q <= accept_c && misalign_c;
  end

  assign bus.err = err_q;
`else
  assign bus.err = 1'b0;
`endif

  assign bus.rdata = rdata_q;
  assign bus.done  = done_q;
  assign bus.stall = stall_c;
endmodule

// File: tb/tb_dmem_responder.sv
// Directed, table-driven bench for dmem_responder (LATENCY=4, ADDR_WIDTH=10).
module tb_dmem_responder;
  localparam int unsigned LAT = 4;
  localparam int unsigned AW  = 10;

  typedef struct {
    logic        we;
    logic [15:0] a;
    logic [15:0] d;
    logic [15:0] exp_rd;
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  int   n_run  = 0;
  int   n_fail = 0;

  dmem_if bus ();

  dmem_responder #(.LATENCY(LAT), .ADDR_WIDTH(AW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_run++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // One request from an IDLE cycle; reports completion cycle index, stall count, rdata and err.
  task automatic access(input logic we, input logic [15:0] a, input logic [15:0] d,
                        output logic [15:0] rd, output int t_done, output int nstall,
                        output logic e);
    rd = '0; e = 1'b0; t_done = -1; nstall = 0;
    @(negedge clk);
    bus.MemOp = 1'b1; bus.MemWrite = we; bus.addr = a; bus.wdata = d;
    #1;
    for (int t = 0; t < 40; t++) begin
      if (t > 0) begin
        @(negedge clk);
        bus.MemOp = 1'b0;
        #1;
      end
      if (bus.stall) nstall++;
      if (bus.done) begin
        t_done = t; rd = bus.rdata; e = bus.err;
        break;
      end
    end
    bus.MemOp = 1'b0;
  endtask

  initial begin
    vec_t        vecs [8];
    logic [15:0] rd;
    logic        e;
    int          t_done, nstall, ndone, first_done, second_done;

    vecs[0] = '{1'b1, 16'h0010, 16'hBEEF, 16'h0000};
    vecs[1] = '{1'b0, 16'h0010, 16'h0000, 16'hBEEF};
    vecs[2] = '{1'b1, 16'h0802, 16'hA5A5, 16'hBEEF};
    vecs[3] = '{1'b0, 16'h0002, 16'h0000, 16'hA5A5};
    vecs[4] = '{1'b1, 16'h07FE, 16'h1357, 16'hA5A5};
    vecs[5] = '{1'b0, 16'hFFFE, 16'h0000, 16'h1357};
    vecs[6] = '{1'b1, 16'h0000, 16'h0001, 16'h1357};
    vecs[7] = '{1'b0, 16'h0000, 16'h0000, 16'h0001};

    rst = 1'b1;
    bus.MemOp = 1'b0; bus.MemWrite = 1'b0; bus.addr = '0; bus.wdata = '0;
    @(negedge clk);
    @(negedge clk);
    check("reset_stall", 32'(bus.stall), 32'd0);
    check("reset_done",  32'(bus.done),  32'd0);
    check("reset_err",   32'(bus.err),   32'd0);
    check("reset_rdata", 32'(bus.rdata), 32'd0);
    rst = 1'b0;

    for (int i = 0; i < 8; i++) begin
      access(vecs[i].we, vecs[i].a, vecs[i].d, rd, t_done, nstall, e);
      check($sformatf("vec%0d_done_cycle", i), 32'(t_done), 32'(LAT + 1));
      check($sformatf("vec%0d_stall_cycles", i), 32'(nstall), 32'(LAT + 1));
      check($sformatf("vec%0d_rdata", i), 32'(rd), 32'(vecs[i].exp_rd));
      check($sformatf("vec%0d_err", i), 32'(e), 32'd0);
    end

    // Misaligned load of the word at 0x0010
    access(1'b0, 16'h0011, 16'h0000, rd, t_done, nstall, e);
`ifdef DMEM_ALIGN_CHECK_EN
    check("mis_done_cycle", 32'(t_done), 32'd1);
    check("mis_stall_cycles", 32'(nstall), 32'd1);
    check("mis_rdata", 32'(rd), 32'h0000);
    check("mis_err", 32'(e), 32'd1);
`else
    check("mis_done_cycle", 32'(t_done), 32'(LAT + 1));
    check("mis_stall_cycles", 32'(nstall), 32'(LAT + 1));
    check("mis_rdata", 32'(rd), 32'hBEEF);
    check("mis_err", 32'(e), 32'd0);
`endif
    @(negedge clk);
    check("after_mis_err", 32'(bus.err), 32'd0);
    access(1'b0, 16'h0010, 16'h0000, rd, t_done, nstall, e);
    check("mis_word_intact", 32'(rd), 32'hBEEF);

    // Back-to-back loads with MemOp held through the second DONE
    ndone = 0; first_done = -1; second_done = -1;
    @(negedge clk);
    bus.MemOp = 1'b1; bus.MemWrite = 1'b0; bus.addr = 16'h0002; bus.wdata = '0;
    for (int t = 0; t < 20; t++) begin
      if (t > 0) @(negedge clk);
      if (t == 12) bus.MemOp = 1'b0;
      #1;
      if (t == 12) check("b2b_no_third", 32'(bus.stall), 32'd0);
      if (bus.done) begin
        ndone++;
        if (ndone == 1) first_done = t;
        if (ndone == 2) second_done = t;
      end
    end
    check("b2b_done_count", 32'(ndone), 32'd2);
    check("b2b_first_done", 32'(first_done), 32'(LAT + 1));
    check("b2b_second_done", 32'(second_done), 32'(2 * LAT + 3));
    check("b2b_rdata", 32'(bus.rdata), 32'hA5A5);

    // Request latches must ignore bus changes after acceptance
    t_done = -1;
    @(negedge clk);
    bus.MemOp = 1'b1; bus.MemWrite = 1'b1; bus.addr = 16'h0020; bus.wdata = 16'h1234;
    for (int t = 1; t < 40; t++) begin
      @(negedge clk);
      bus.MemOp = 1'b0;
      if (t == 2) begin
        bus.addr = 16'hFFFF; bus.wdata = 16'hFFFF; bus.MemWrite = 1'b0;
      end
      #1;
      if (bus.done) begin
        t_done = t;
        break;
      end
    end
    check("latch_done_cycle", 32'(t_done), 32'(LAT + 1));
    access(1'b0, 16'h0020, 16'h0000, rd, t_done, nstall, e);
    check("latch_target_word", 32'(rd), 32'h1234);
    access(1'b0, 16'hFFFE, 16'h0000, rd, t_done, nstall, e);
    check("latch_no_stray_write", 32'(rd), 32'h1357);

    // Reset in BUSY aborts a store
    access(1'b1, 16'h0030, 16'h2222, rd, t_done, nstall, e);
    @(negedge clk);
    bus.MemOp = 1'b1; bus.MemWrite = 1'b1; bus.addr = 16'h0030; bus.wdata = 16'h5555;
    @(negedge clk);
    bus.MemOp = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("rst_busy_stall", 32'(bus.stall), 32'd0);
    check("rst_busy_done",  32'(bus.done),  32'd0);
    check("rst_busy_rdata", 32'(bus.rdata), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("rst_release_stall", 32'(bus.stall), 32'd0);
    access(1'b0, 16'h0030, 16'h0000, rd, t_done, nstall, e);
    check("rst_aborted_write", 32'(rd), 32'h2222);
    check("rst_after_done_cycle", 32'(t_done), 32'(LAT + 1));

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule
